// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default widths, the hardwired-zero register id and the requester encodings.
package rf_writeback_arbiter_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int REG_ID_W_DEF = 4;
  localparam int ZERO_REG     = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rf_writeback_arbiter_rr_arbiter_2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// i_force_a overrides the pointer so the older requester (A) goes first.
// While rst is high no grant is issued and the pointer returns to "last=B".
module rr_arbiter_2
  import rf_writeback_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_force_a,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  req_e r_last;

  // Grant selection: a lone request always wins; contention alternates unless A is forced.
  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (!rst) begin
      if (i_req_a && i_req_b) begin
        if (i_force_a || (r_last == REQ_B)) begin
          o_gnt_a = 1'b1;
        end else begin
          o_gnt_b = 1'b1;
        end
      end else if (i_req_a) begin
        o_gnt_a = 1'b1;
      end else if (i_req_b) begin
        o_gnt_b = 1'b1;
      end
    end
  end

  // Pointer moves only when a grant actually happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ_B;
    end else if (o_gnt_a) begin
      r_last <= REQ_A;
    end else if (o_gnt_b) begin
      r_last <= REQ_B;
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the register file's single write port between ALU (A) and load (B) writeback.
// Winning request is registered into an output stage that drives DstReg/DstData/WriteReg.
// Optional macro RF_WB_ARB_CONFLICT_CNT_EN adds a saturating contention counter (conflict_cnt).
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [REG_ID_W-1:0] a_reg,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [REG_ID_W-1:0] b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  output logic                WriteReg,
  output logic [REG_ID_W-1:0] DstReg,
  output logic [DATA_W-1:0]   DstData,
  output logic                busy
`ifdef RF_WB_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]         conflict_cnt
`endif
);

  logic                w_gnt_a;
  logic                w_gnt_b;
  logic                w_gnt_any;
  logic                w_same_reg;
  logic [REG_ID_W-1:0] w_sel_reg;
  logic [DATA_W-1:0]   w_sel_data;

  logic                r_busy;
  logic                r_write;
  logic [REG_ID_W-1:0] r_dst_reg;
  logic [DATA_W-1:0]   r_dst_data;

  // Same destination: A is older, so it must be written first and B's value lands last.
  assign w_same_reg = (a_reg == b_reg);

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req_a   (a_valid),
    .i_req_b   (b_valid),
    .i_force_a (w_same_reg),
    .o_gnt_a   (w_gnt_a),
    .o_gnt_b   (w_gnt_b)
  );

  assign a_ready    = w_gnt_a;
  assign b_ready    = w_gnt_b;
  assign w_gnt_any  = w_gnt_a | w_gnt_b;
  assign w_sel_reg  = w_gnt_a ? a_reg  : b_reg;
  assign w_sel_data = w_gnt_a ? a_data : b_data;

  // Output stage: load the granted write; writes to the zero register occupy the stage without enabling the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_write    <= 1'b0;
      r_dst_reg  <= '0;
      r_dst_data <= '0;
    end else begin
      r_busy  <= w_gnt_any;
      r_write <= w_gnt_any && (w_sel_reg != REG_ID_W'(ZERO_REG));
      if (w_gnt_any) begin
        r_dst_reg  <= w_sel_reg;
        r_dst_data <= w_sel_data;
      end
    end
  end

  assign WriteReg = r_write;
  assign DstReg   = r_dst_reg;
  assign DstData  = r_dst_data;
  assign busy     = r_busy;

`ifdef RF_WB_ARB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;

  // Count cycles where both requesters contend, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (a_valid && b_valid && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with immediate-assertion checks.
// Also covers conflict_cnt when RF_WB_ARB_CONFLICT_CNT_EN is defined.
module tb_rf_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        b_ready;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        busy;
`ifdef RF_WB_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int total;
  int bad;
  logic [15:0] rf [16];

  rf_writeback_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .WriteReg (WriteReg),
    .DstReg   (DstReg),
    .DstData  (DstData),
    .busy     (busy)
`ifdef RF_WB_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple register-file model fed by the DUT's write port.
  always @(posedge clk) begin
    if (WriteReg) rf[DstReg] <= DstData;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    rst = 1'b1;
    a_valid = 1'b0; a_reg = 4'd0; a_data = 16'h0;
    b_valid = 1'b0; b_reg = 4'd0; b_data = 16'h0;

    // Reset for two cycles; a valid during reset must not be accepted.
    tick();
    a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h9999;
    #1;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("rst_WriteReg", 32'(WriteReg), 32'd0);
    check("rst_DstReg", 32'(DstReg), 32'd0);
    check("rst_DstData", 32'(DstData), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    a_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("idle_WriteReg", 32'(WriteReg), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single A write.
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'hA5A5;
    #1;
    check("single_a_ready", 32'(a_ready), 32'd1);
    check("single_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    check("single_WriteReg", 32'(WriteReg), 32'd1);
    check("single_DstReg", 32'(DstReg), 32'd1);
    check("single_DstData", 32'(DstData), 32'hA5A5);
    tick();
    check("single_after_WriteReg", 32'(WriteReg), 32'd0);
    check("single_hold_DstReg", 32'(DstReg), 32'd1);
    check("single_hold_DstData", 32'(DstData), 32'hA5A5);

    // Write to register 0 from B: accepted but suppressed.
    b_valid = 1'b1; b_reg = 4'd0; b_data = 16'hFFFF;
    #1;
    check("r0_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("r0_busy", 32'(busy), 32'd1);
    check("r0_WriteReg", 32'(WriteReg), 32'd0);
    check("r0_DstReg", 32'(DstReg), 32'd0);
    tick();
    check("r0_rf0", 32'(rf[0]), 32'd0);
    check("r0_after_busy", 32'(busy), 32'd0);

    // Contention with distinct registers; last grant was B so A goes first.
    a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h1111;
    b_valid = 1'b1; b_reg = 4'd3; b_data = 16'h2222;
    #1;
    check("alt1_a_ready", 32'(a_ready), 32'd1);
    check("alt1_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_data = 16'h1112;
    check("alt1_out", {WriteReg, 11'd0, DstReg, DstData}, {1'b1, 11'd0, 4'd2, 16'h1111});
    #1;
    check("alt2_b_ready", 32'(b_ready), 32'd1);
    check("alt2_a_ready", 32'(a_ready), 32'd0);
    tick();
    b_data = 16'h2223;
    check("alt2_out", {WriteReg, 11'd0, DstReg, DstData}, {1'b1, 11'd0, 4'd3, 16'h2222});
    #1;
    check("alt3_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_data = 16'h1113;
    check("alt3_out", {WriteReg, 11'd0, DstReg, DstData}, {1'b1, 11'd0, 4'd2, 16'h1112});
    #1;
    check("alt4_b_ready", 32'(b_ready), 32'd1);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("alt4_out", {WriteReg, 11'd0, DstReg, DstData}, {1'b1, 11'd0, 4'd3, 16'h2223});
    tick();
    check("alt_idle_WriteReg", 32'(WriteReg), 32'd0);

    // Single A write leaves the pointer favouring B.
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'h0055;
    #1;
    check("pre_same_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;

    // Same destination: A first despite the pointer, B's value ends up in the file.
    a_valid = 1'b1; a_reg = 4'd4; a_data = 16'h3C3C;
    b_valid = 1'b1; b_reg = 4'd4; b_data = 16'h5A5A;
    #1;
    check("same_a_ready", 32'(a_ready), 32'd1);
    check("same_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    check("same1_out", {WriteReg, 11'd0, DstReg, DstData}, {1'b1, 11'd0, 4'd4, 16'h3C3C});
    #1;
    check("same2_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("same2_out", {WriteReg, 11'd0, DstReg, DstData}, {1'b1, 11'd0, 4'd4, 16'h5A5A});
    tick();
    check("same_rf4", 32'(rf[4]), 32'h5A5A);
    check("same_rf5", 32'(rf[5]), 32'h0055);

    // Reset mid-write after three contended cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_reg = 4'd6; a_data = 16'h0606;
    b_valid = 1'b1; b_reg = 4'd7; b_data = 16'h0707;
    #1;
    check("mid1_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("mid2_b_ready", 32'(b_ready), 32'd1);
    tick();
    check("mid3_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("mid_WriteReg", 32'(WriteReg), 32'd1);
    check("mid_DstReg", 32'(DstReg), 32'd6);
`ifdef RF_WB_ARB_CONFLICT_CNT_EN
    check("mid_conflict_cnt", 32'(conflict_cnt), 32'd3);
`endif
    rst = 1'b1;
    #1;
    check("midrst_a_ready", 32'(a_ready), 32'd0);
    check("midrst_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("midrst_WriteReg", 32'(WriteReg), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_DstReg", 32'(DstReg), 32'd0);
    check("midrst_DstData", 32'(DstData), 32'd0);
`ifdef RF_WB_ARB_CONFLICT_CNT_EN
    check("midrst_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check("end_WriteReg", 32'(WriteReg), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
